rom_dump_controller: RTL and testbench
======================================

Name: rom_dump_controller

Overview:
- Parametrised successor to the per-chip ROM reader: one controller drives up to CHIP_COUNT bipolar PROMs (IP3601, IP3604 class) sharing one address bus and one data bus.
- Supports manual step mode (increment/decrement address, hold data for LED/7-seg) and auto-dump mode (scan 0..last_address, stream every word out on a valid/ready interface toward a UART/host link).
- Sits between the board top level (buttons, switches, display) and the GPIO pins of the chip socket.

Parameters:
- CHIP_COUNT, 2, number of chips sharing the buses; one active-low enable per chip.
- CHIP_INDEX_WIDTH, 1, width of chip_index; must satisfy 2**CHIP_INDEX_WIDTH >= CHIP_COUNT.
- ADDRESS_WIDTH, 9, width of the shared address bus.
- DATA_WIDTH, 8, width of the shared data bus.
- SETTLE_CYCLES, 4, clocks between address/enable change and data sample, range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- chip_index  in  CHIP_INDEX_WIDTH  selected chip; sampled only in IDLE.
- last_address  in  ADDRESS_WIDTH  top address of the selected chip (255 for IP3601, 511 for IP3604); sampled only in IDLE.
- data_mask  in  DATA_WIDTH  AND-mask applied to captured data (8'h0F for 4-bit chips).
- increment_address  in  1  single-cycle pulse, pre-debounced, active-high.
- decrement_address  in  1  single-cycle pulse, pre-debounced, active-high.
- start_dump  in  1  single-cycle pulse that starts auto-dump.
- abort  in  1  single-cycle pulse that cancels auto-dump.
- chip_data_port  in  DATA_WIDTH  data from the socket.
- chip_address_port  out  ADDRESS_WIDTH  address to the socket.
- chip_enable_n  out  CHIP_COUNT  one-hot active-low chip enables.
- held_data  out  DATA_WIDTH  last captured word; feeds the LEDs.
- stream_data  out  DATA_WIDTH  dump word.
- stream_address  out  ADDRESS_WIDTH  address of stream_data.
- stream_valid  out  1  stream handshake valid.
- stream_ready  in  1  stream handshake ready from the consumer.
- stream_last  out  1  high with the final word of a dump.
- busy  out  1  high in any state except IDLE.
- dump_done  out  1  one-cycle pulse when a dump completes.

Behaviour:
- Reset values:
  - state IDLE; chip_address_port = 0; chip_enable_n = all ones.
  - held_data = 0; stream_* = 0; busy = 0; dump_done = 0.
  - internal address = 0; first read is triggered automatically after reset (IDLE -> SETUP).
- States: IDLE, SETUP, SETTLE, CAPTURE, EMIT, DONE.
- IDLE:
  - chip_enable_n stays driven for the latched chip.
  - increment_address: address+1; at last_address it wraps to 0.
  - decrement_address: address-1; at 0 it wraps to last_address.
  - Both pulses in the same cycle: no change, no read.
  - After any address change -> SETUP.
  - start_dump: address = 0, dump flag set -> SETUP. start_dump has priority over inc/dec in the same cycle.
  - A change of chip_index while in IDLE: latch the new chip, reset address to 0 -> SETUP.
- SETUP (1 cycle):
  - Drive chip_address_port = address and chip_enable_n[chip] = 0, all others 1.
  - Load the settle counter with SETTLE_CYCLES-1 -> SETTLE.
- SETTLE: count down; at 0 -> CAPTURE. First sample occurs SETTLE_CYCLES+1 clocks after SETUP entry.
- CAPTURE (1 cycle):
  - held_data <= chip_data_port & data_mask.
  - Manual mode -> IDLE.
  - Dump mode: load stream_data and stream_address; stream_last = (address == last_address) -> EMIT.
- EMIT:
  - stream_valid = 1.
  - stream_data, stream_address and stream_last stay stable until stream_valid && stream_ready.
  - On handshake, stream_valid drops next cycle.
  - If last word -> DONE; else address+1 -> SETUP.
- DONE (1 cycle): dump_done = 1, dump flag cleared, address held at last_address -> IDLE.
- abort in any dump state:
  - Next state IDLE; stream_valid = 0; no dump_done.
  - Address retains its current value.
  - Abort in EMIT in the same cycle as a handshake: the word counts as transferred, then abort applies.
- inc/dec/start_dump outside IDLE are ignored; they are not queued.
- Reset mid-dump returns everything to reset values within one clock.
- last_address >= 2**ADDRESS_WIDTH is impossible by width. A last_address of 0 gives a dump of one word with stream_last = 1.
- busy = (state != IDLE).

Test Plan:
- Reset release with ROM model mem[i] = i ^ 8'hA5, SETTLE_CYCLES = 4 -> chip_enable_n = 2'b10 after SETUP; held_data = 8'hA5 at address 0, sampled exactly 5 clocks after SETUP.
- chip_index = 0, last_address = 255, data_mask = 8'h0F, decrement at address 0 -> address 255, held_data = 8'h0A.
- Ten increments from address 250 -> address wraps through 255 to 4; held_data matches the model after each settle. Inc and dec in the same cycle -> address unchanged, busy stays 0.
- chip_index = 1, last_address = 511, start_dump with stream_ready always 1:
  - 512 handshakes, addresses 0..511 in order, data matching the model.
  - stream_last only on address 511; dump_done pulses once.
- Same dump with stream_ready toggled pseudo-randomly -> stream_data/stream_address stable while stream_valid && !stream_ready; no word lost or duplicated.
- abort after 100 words -> IDLE next cycle, stream_valid = 0, no dump_done. Separately, reset asserted mid-SETTLE -> all outputs at reset values next clock.

Source files
------------

// File: rtl/rom_dump_controller_if.sv
// Bundles the chip-socket, board-control and stream signals of the PROM dump controller.
// The master modport is the controller side; slave is the board/host side.
interface rom_dump_controller_if #(
  parameter int CHIP_COUNT       = 2,
  parameter int CHIP_INDEX_WIDTH = 1,
  parameter int ADDRESS_WIDTH    = 9,
  parameter int DATA_WIDTH       = 8
) ();
  logic [CHIP_INDEX_WIDTH-1:0] chip_index;
  logic [ADDRESS_WIDTH-1:0]    last_address;
  logic [DATA_WIDTH-1:0]       data_mask;
  logic                        increment_address;
  logic                        decrement_address;
  logic                        start_dump;
  logic                        abort;
  logic [DATA_WIDTH-1:0]       chip_data_port;
  logic [ADDRESS_WIDTH-1:0]    chip_address_port;
  logic [CHIP_COUNT-1:0]       chip_enable_n;
  logic [DATA_WIDTH-1:0]       held_data;
  logic [DATA_WIDTH-1:0]       stream_data;
  logic [ADDRESS_WIDTH-1:0]    stream_address;
  logic                        stream_valid;
  logic                        stream_ready;
  logic                        stream_last;
  logic                        busy;
  logic                        dump_done;

  modport master (
    input  chip_index, last_address, data_mask, increment_address, decrement_address,
           start_dump, abort, chip_data_port, stream_ready,
    output chip_address_port, chip_enable_n, held_data, stream_data, stream_address,
           stream_valid, stream_last, busy, dump_done
  );

  modport slave (
    output chip_index, last_address, data_mask, increment_address, decrement_address,
           start_dump, abort, chip_data_port, stream_ready,
    input  chip_address_port, chip_enable_n, held_data, stream_data, stream_address,
           stream_valid, stream_last, busy, dump_done
  );
endinterface

// File: rtl/rom_dump_controller.sv
// Multi-chip bipolar PROM reader: manual address stepping with held data for the LEDs,
// plus an auto-dump that streams every word of the selected chip over valid/ready.
module rom_dump_controller #(
  parameter int CHIP_COUNT       = 2,
  parameter int CHIP_INDEX_WIDTH = 1,
  parameter int ADDRESS_WIDTH    = 9,
  parameter int DATA_WIDTH       = 8,
  parameter int SETTLE_CYCLES    = 4
) (
  input logic                  clk,
  input logic                  reset,
  rom_dump_controller_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SETTLE, CAPTURE, EMIT, DONE} state_e;

  state_e                      state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]    address_q, address_d;
  logic [ADDRESS_WIDTH-1:0]    lastAddr_q, lastAddr_d;
  logic [ADDRESS_WIDTH-1:0]    portAddr_q, portAddr_d;
  logic [CHIP_INDEX_WIDTH-1:0] chipSel_q, chipSel_d;
  logic [CHIP_COUNT-1:0]       enableN_q, enableN_d;
  logic [7:0]                  settle_q, settle_d;
  logic [DATA_WIDTH-1:0]       held_q, held_d;
  logic [DATA_WIDTH-1:0]       streamData_q, streamData_d;
  logic [ADDRESS_WIDTH-1:0]    streamAddr_q, streamAddr_d;
  logic                        streamLast_q, streamLast_d;
  logic                        dumpMode_q, dumpMode_d;
  logic                        pendingRead_q, pendingRead_d;

  logic stepReq;
  logic chipChange;
  logic dumpAbort;
  logic [DATA_WIDTH-1:0] maskedData;

  assign stepReq    = bus.increment_address ^ bus.decrement_address;
  assign chipChange = (bus.chip_index != chipSel_q);
  assign dumpAbort  = bus.abort && dumpMode_q;
  assign maskedData = bus.chip_data_port & bus.data_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      address_q     <= '0;
      lastAddr_q    <= '0;
      portAddr_q    <= '0;
      chipSel_q     <= '0;
      enableN_q     <= '1;
      settle_q      <= '0;
      held_q        <= '0;
      streamData_q  <= '0;
      streamAddr_q  <= '0;
      streamLast_q  <= 1'b0;
      dumpMode_q    <= 1'b0;
      pendingRead_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      address_q     <= address_d;
      lastAddr_q    <= lastAddr_d;
      portAddr_q    <= portAddr_d;
      chipSel_q     <= chipSel_d;
      enableN_q     <= enableN_d;
      settle_q      <= settle_d;
      held_q        <= held_d;
      streamData_q  <= streamData_d;
      streamAddr_q  <= streamAddr_d;
      streamLast_q  <= streamLast_d;
      dumpMode_q    <= dumpMode_d;
      pendingRead_q <= pendingRead_d;
    end
  end

  // Abort only matters while a dump is running; in EMIT dumpMode_q is always set.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start_dump || chipChange || pendingRead_q || stepReq) state_d = SETUP;
      SETUP:   state_d = dumpAbort ? IDLE : SETTLE;
      SETTLE:  if (dumpAbort) state_d = IDLE;
               else if (settle_q == 8'd0) state_d = CAPTURE;
      CAPTURE: state_d = (dumpMode_q && !dumpAbort) ? EMIT : IDLE;
      EMIT:    if (bus.abort) state_d = IDLE;
               else if (bus.stream_ready) state_d = streamLast_q ? DONE : SETUP;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    address_d     = address_q;
    lastAddr_d    = lastAddr_q;
    portAddr_d    = portAddr_q;
    chipSel_d     = chipSel_q;
    enableN_d     = enableN_q;
    settle_d      = settle_q;
    held_d        = held_q;
    streamData_d  = streamData_q;
    streamAddr_d  = streamAddr_q;
    streamLast_d  = streamLast_q;
    dumpMode_d    = dumpMode_q;
    pendingRead_d = pendingRead_q;
    unique case (state_q)
      IDLE: begin
        lastAddr_d    = bus.last_address;
        chipSel_d     = bus.chip_index;
        pendingRead_d = 1'b0;
        if (bus.start_dump) begin
          address_d  = '0;
          dumpMode_d = 1'b1;
        end else if (chipChange || pendingRead_q) begin
          address_d = '0;
        end else if (stepReq && bus.increment_address) begin
          address_d = (address_q >= bus.last_address) ? '0 : address_q + 1'b1;
        end else if (stepReq) begin
          address_d = (address_q == '0 || address_q > bus.last_address) ?
                      bus.last_address : address_q - 1'b1;
        end
      end
      SETUP: begin
        portAddr_d = address_q;
        for (int i = 0; i < CHIP_COUNT; i++) enableN_d[i] = (chipSel_q != CHIP_INDEX_WIDTH'(i));
        settle_d = 8'(SETTLE_CYCLES - 1);
      end
      SETTLE: if (settle_q != 8'd0) settle_d = settle_q - 8'd1;
      CAPTURE: begin
        held_d = maskedData;
        if (dumpMode_q) begin
          streamData_d = maskedData;
          streamAddr_d = address_q;
          streamLast_d = (address_q == lastAddr_q);
        end
      end
      EMIT: if (bus.stream_ready && !streamLast_q && !bus.abort) address_d = address_q + 1'b1;
      DONE: begin
        dumpMode_d = 1'b0;
        address_d  = lastAddr_q;
      end
      default: ;
    endcase
    if (dumpAbort && state_q != IDLE) dumpMode_d = 1'b0;
  end

  always_comb begin
    bus.busy              = (state_q != IDLE);
    bus.stream_valid      = (state_q == EMIT);
    bus.dump_done         = (state_q == DONE);
    bus.chip_address_port = portAddr_q;
    bus.chip_enable_n     = enableN_q;
    bus.held_data         = held_q;
    bus.stream_data       = streamData_q;
    bus.stream_address    = streamAddr_q;
    bus.stream_last       = streamLast_q;
  end

endmodule

// File: tb/tb_rom_dump_controller.sv
// Randomized bench for rom_dump_controller against a behavioural PROM and address model.
module tb_rom_dump_controller;
  localparam int CC = 2, CIW = 1, AW = 9, DW = 8, SETTLE = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int modelAddr = 0;
  int modelLast = 255;
  int modelChip = 0;

  rom_dump_controller_if #(.CHIP_COUNT(CC), .CHIP_INDEX_WIDTH(CIW), .ADDRESS_WIDTH(AW),
                           .DATA_WIDTH(DW)) bus ();

  rom_dump_controller #(.CHIP_COUNT(CC), .CHIP_INDEX_WIDTH(CIW), .ADDRESS_WIDTH(AW),
                        .DATA_WIDTH(DW), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [7:0] romWord(input int chip, input int addr);
    logic [8:0] a;
    a = addr[8:0];
    if (chip == 0) return a[7:0] ^ 8'hA5;
    return a[7:0] ^ (a[8] ? 8'h3C : 8'h5A);
  endfunction

  // Combinational socket model; an unselected bus floats high.
  always_comb begin
    if (!bus.chip_enable_n[0])      bus.chip_data_port = romWord(0, int'(bus.chip_address_port));
    else if (!bus.chip_enable_n[1]) bus.chip_data_port = romWord(1, int'(bus.chip_address_port));
    else                            bus.chip_data_port = 8'hFF;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic inc, input logic dec, input logic start, input logic ab);
    bus.increment_address = inc;
    bus.decrement_address = dec;
    bus.start_dump        = start;
    bus.abort             = ab;
    @(negedge clk);
    bus.increment_address = 1'b0;
    bus.decrement_address = 1'b0;
    bus.start_dump        = 1'b0;
    bus.abort             = 1'b0;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    if (bus.busy) checkOutput("idleTimeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic manualStep(input logic inc, input logic dec);
    int cyc;
    applyStimulus(inc, dec, 1'b0, 1'b0);
    waitIdle(cyc);
    if (inc) modelAddr = (modelAddr == modelLast) ? 0 : modelAddr + 1;
    else     modelAddr = (modelAddr == 0) ? modelLast : modelAddr - 1;
    checkOutput("stepAddress", 32'(bus.chip_address_port), 32'(modelAddr));
    checkOutput("stepHeld", 32'(bus.held_data), 32'(romWord(modelChip, modelAddr) & bus.data_mask));
    checkOutput("stepBusyCycles", 32'(cyc), 32'(SETTLE + 2));
  endtask

  task automatic selectChip(input int chip, input int last);
    int cyc;
    bus.chip_index   = chip[CIW-1:0];
    bus.last_address = last[AW-1:0];
    @(negedge clk);
    waitIdle(cyc);
    modelChip = chip;
    modelLast = last;
    modelAddr = 0;
    checkOutput("chipEnable", 32'(bus.chip_enable_n), (chip == 0) ? 32'h2 : 32'h1);
    checkOutput("chipHeld", 32'(bus.held_data), 32'(romWord(chip, 0) & bus.data_mask));
  endtask

  task automatic runDump(input bit randomReady, input int abortAfter);
    int words, doneCount;
    bit stall, aborted, finished;
    logic [DW-1:0] savedData;
    logic [AW-1:0] savedAddr;
    logic savedLast;
    words = 0; doneCount = 0; stall = 0; aborted = 0; finished = 0;
    savedData = '0; savedAddr = '0; savedLast = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    for (int cyc = 0; cyc < 12000; cyc++) begin
      bus.abort = 1'b0;
      if (aborted) break;
      if (bus.dump_done) begin
        doneCount++;
        finished = 1;
        break;
      end
      if (stall) begin
        checkOutput("stableValid", 32'(bus.stream_valid), 32'd1);
        checkOutput("stableData", 32'(bus.stream_data), 32'(savedData));
        checkOutput("stableAddr", 32'(bus.stream_address), 32'(savedAddr));
        checkOutput("stableLast", 32'(bus.stream_last), 32'(savedLast));
      end
      stall = 0;
      bus.stream_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.stream_valid && bus.stream_ready) begin
        checkOutput("wordAddr", 32'(bus.stream_address), 32'(words));
        checkOutput("wordData", 32'(bus.stream_data), 32'(romWord(modelChip, words) & bus.data_mask));
        checkOutput("wordLast", 32'(bus.stream_last), 32'(words == modelLast));
        words++;
        if (abortAfter > 0 && words == abortAfter) begin
          bus.abort = 1'b1;
          aborted = 1;
        end
      end else if (bus.stream_valid) begin
        stall = 1;
        savedData = bus.stream_data;
        savedAddr = bus.stream_address;
        savedLast = bus.stream_last;
      end
      @(negedge clk);
    end
    if (aborted) begin
      checkOutput("abortValid", 32'(bus.stream_valid), 32'd0);
      checkOutput("abortBusy", 32'(bus.busy), 32'd0);
    end else if (!finished) begin
      checkOutput("dumpTimeout", 32'(finished), 32'd1);
    end
    bus.stream_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.dump_done) doneCount++;
    end
    checkOutput("dumpWords", 32'(words), aborted ? 32'(abortAfter) : 32'(modelLast + 1));
    checkOutput("dumpDoneCount", 32'(doneCount), aborted ? 32'd0 : 32'd1);
    checkOutput("dumpEndBusy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int cyc;
    logic [AW-1:0] addrBefore;
    logic [DW-1:0] heldBefore;
    bus.chip_index = '0;
    bus.last_address = 9'd255;
    bus.data_mask = 8'hFF;
    bus.stream_ready = 1'b0;
    bus.increment_address = 1'b0;
    bus.decrement_address = 1'b0;
    bus.start_dump = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetEnable", 32'(bus.chip_enable_n), 32'h3);
    checkOutput("resetHeld", 32'(bus.held_data), 32'h0);
    checkOutput("resetBusy", 32'(bus.busy), 32'h0);
    checkOutput("resetValid", 32'(bus.stream_valid), 32'h0);

    reset = 1'b0;
    @(negedge clk);
    waitIdle(cyc);
    checkOutput("firstReadCycles", 32'(cyc), 32'(SETTLE + 2));
    checkOutput("firstEnable", 32'(bus.chip_enable_n), 32'h2);
    checkOutput("firstHeld", 32'(bus.held_data), 32'hA5);

    bus.data_mask = 8'h0F;
    manualStep(1'b0, 1'b1);
    checkOutput("wrapDownHeld", 32'(bus.held_data), 32'h0A);
    repeat (5) manualStep(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) manualStep(1'b1, 1'b0);
    checkOutput("wrapUpAddress", 32'(bus.chip_address_port), 32'd4);

    addrBefore = bus.chip_address_port;
    heldBefore = bus.held_data;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("bothBusy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    checkOutput("bothBusyLater", 32'(bus.busy), 32'd0);
    checkOutput("bothAddress", 32'(bus.chip_address_port), 32'(addrBefore));
    checkOutput("bothHeld", 32'(bus.held_data), 32'(heldBefore));

    for (int i = 0; i < 20; i++) begin
      bus.data_mask = 8'($urandom);
      if ($urandom_range(0, 1) == 0) manualStep(1'b1, 1'b0);
      else                           manualStep(1'b0, 1'b1);
    end

    bus.data_mask = 8'hFF;
    selectChip(1, 511);
    runDump(1'b0, 0);
    checkOutput("dumpEndAddress", 32'(bus.chip_address_port), 32'd511);
    bus.data_mask = 8'($urandom);
    runDump(1'b1, 0);
    bus.data_mask = 8'hFF;
    runDump(1'b0, 100);

    selectChip(0, 0);
    runDump(1'b1, 0);

    bus.last_address = 9'd255;
    modelLast = 255;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midResetEnable", 32'(bus.chip_enable_n), 32'h3);
    checkOutput("midResetBusy", 32'(bus.busy), 32'd0);
    checkOutput("midResetHeld", 32'(bus.held_data), 32'd0);
    checkOutput("midResetAddress", 32'(bus.chip_address_port), 32'd0);
    checkOutput("midResetStream", {bus.stream_data, 7'd0, bus.stream_address, 6'd0, bus.stream_valid, bus.stream_last},
                32'd0);
    reset = 1'b0;
    @(negedge clk);
    waitIdle(cyc);
    checkOutput("postResetHeld", 32'(bus.held_data), 32'(romWord(0, 0)));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
